// File: rtl/riscv_pkg.sv
// Shared types for the integer divide unit: operation encoding (funct3[1:0])
// and FSM state encoding, plus small decode helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // DIV and REM treat operands as two's complement.
  function automatic logic op_is_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic op_is_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (RISC-V DIV/DIVU/REM/REMU semantics).
// One quotient bit per cycle on operand magnitudes, sign fix-up at the end,
// fast paths for divide-by-zero and signed overflow.
//
// Handshake: the unit accepts a request on a rising edge where ready_o=1,
// start_i=1 and flush_i=0. ready_o is high only in IDLE; start_i is ignored
// otherwise. done_o is a one-cycle pulse, registered on the edge that leaves
// DONE, and result_o is valid from that cycle and held until the next
// completion. flush_i returns to IDLE at the next edge with no done_o pulse;
// rst overrides everything.
module div_unit
  import riscv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    div_op_i,
  input  logic [DW-1:0] operand_a_i,
  input  logic [DW-1:0] operand_b_i,
  input  logic          flush_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [DW-1:0] result_o,
  output div_state_e    dbg_state_o
);

  localparam logic [DW-1:0] CNT_LAST = DW'(DW - 1);
  localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

  div_state_e    state_q, state_d;
  div_op_e       op_q;
  div_op_e       op_in;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] dvd_q;     // dividend magnitude shifting out, quotient shifting in
  logic [DW-1:0] rem_q;     // partial remainder
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] result_q;
  logic          done_q;

  logic          accept;
  logic          fast_path;
  logic [DW-1:0] a_mag_in;
  logic [DW-1:0] b_mag;
  logic [DW:0]   shifted;
  logic [DW:0]   trial;
  logic          borrow;
  logic          q_neg, r_neg;
  logic [DW-1:0] quotient, remainder, final_result;

  assign op_in       = div_op_e'(div_op_i);
  assign accept      = (state_q == DIV_IDLE) && start_i && !flush_i;
  assign ready_o     = (state_q == DIV_IDLE);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign dbg_state_o = state_q;

  // Request decode: magnitude of the incoming dividend and whether the
  // answer is known without iterating (b==0, or MIN / -1 when signed).
  always_comb begin
    a_mag_in  = (op_is_signed(op_in) && operand_a_i[DW-1]) ? (~operand_a_i + 1'b1) : operand_a_i;
    fast_path = (operand_b_i == '0) ||
                (op_is_signed(op_in) && (operand_a_i == MIN_NEG) && (operand_b_i == ALL_ONES));
  end

  // One restoring step at DW+1 bits: the top bit of the trial difference is
  // the borrow and decides whether the subtraction is kept.
  always_comb begin
    b_mag   = (op_is_signed(op_q) && b_q[DW-1]) ? (~b_q + 1'b1) : b_q;
    shifted = {rem_q, dvd_q[DW-1]};
    trial   = shifted - {1'b0, b_mag};
    borrow  = trial[DW];
  end

  // Sign fix-up and special-case selection for the final result.
  always_comb begin
    q_neg     = op_is_signed(op_q) && (a_q[DW-1] ^ b_q[DW-1]);
    r_neg     = op_is_signed(op_q) && a_q[DW-1];
    quotient  = q_neg ? (~dvd_q + 1'b1) : dvd_q;
    remainder = r_neg ? (~rem_q + 1'b1) : rem_q;
    if (b_q == '0) begin
      quotient  = ALL_ONES;
      remainder = a_q;
    end else if (op_is_signed(op_q) && (a_q == MIN_NEG) && (b_q == ALL_ONES)) begin
      quotient  = a_q;
      remainder = '0;
    end
    final_result = op_is_rem(op_q) ? remainder : quotient;
  end

  // Next-state logic; flush forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (accept) state_d = fast_path ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == CNT_LAST) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush_i) state_d = DIV_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: capture on accept, iterate in CALC, publish result from DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_DIV;
      a_q      <= '0;
      b_q      <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            a_q   <= operand_a_i;
            b_q   <= operand_b_i;
            dvd_q <= a_mag_in;
            rem_q <= '0;
            cnt_q <= '0;
          end
        end
        DIV_CALC: begin
          rem_q <= borrow ? shifted[DW-1:0] : trial[DW-1:0];
          dvd_q <= {dvd_q[DW-2:0], ~borrow};
          cnt_q <= cnt_q + 1'b1;
        end
        DIV_DONE: begin
          if (!flush_i) begin
            result_q <= final_result;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit (DW=32), one task per scenario.
module tb_div_unit;
  import riscv_pkg::*;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [1:0]    div_op_i;
  logic [DW-1:0] operand_a_i;
  logic [DW-1:0] operand_b_i;
  logic          flush_i;
  logic          ready_o;
  logic          done_o;
  logic [DW-1:0] result_o;
  div_state_e    dbg_state_o;

  int checks;
  int failures;

  div_unit #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .div_op_i    (div_op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present a request on the falling edge; it is accepted at the next
  // rising edge (edge N). Returns #1 after edge N with start_i dropped.
  task automatic launch(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    start_i     = 1'b1;
    div_op_i    = op;
    operand_a_i = a;
    operand_b_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Waits for done_o; lat is the number of rising edges after the call point
  // (edge N) at which done_o was first seen high, -1 on timeout.
  task automatic wait_done(input int budget, output logic [DW-1:0] res, output int lat);
    lat = -1;
    res = 'x;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1) begin
        lat = k;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++;
    if (result_o !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
    checks++;
    if (dbg_state_o !== DIV_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, DIV_IDLE); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [DW-1:0] res;
    int lat;
    launch(OP_DIVU, 32'd100, 32'd7);
    checks++;
    if (ready_o !== 1'b0 || dbg_state_o !== DIV_CALC) begin
      failures++; $display("FAIL divu_busy ready=%b state=%0d exp ready=0 state=CALC", ready_o, dbg_state_o);
    end
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", res, 32'd14); end
    checks++;
    if (lat !== DW + 1) begin failures++; $display("FAIL divu_latency got=%0d exp=%0d", lat, DW + 1); end
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd14) begin
      failures++; $display("FAIL done_one_cycle done=%b ready=%b res=%h exp done=0 ready=1 res=e", done_o, ready_o, result_o);
    end
    launch(OP_REMU, 32'd100, 32'd7);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd2 || lat !== DW + 1) begin failures++; $display("FAIL remu_100_7 got=%h lat=%0d exp=2 lat=%0d", res, lat, DW + 1); end
    launch(OP_DIVU, 32'hFFFF_FFFF, 32'd10);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'h1999_9999) begin failures++; $display("FAIL divu_max_10 got=%h exp=19999999", res); end
    launch(OP_REMU, 32'hFFFF_FFFF, 32'd10);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd5) begin failures++; $display("FAIL remu_max_10 got=%h exp=5", res); end
    launch(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd0 || lat !== DW + 1) begin failures++; $display("FAIL divu_no_fast got=%h lat=%0d exp=0 lat=%0d", res, lat, DW + 1); end
  endtask

  task automatic test_signed();
    logic [DW-1:0] res;
    int lat;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=fffffffd", res); end
    launch(OP_REM, 32'hFFFF_FFF9, 32'd2);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", res); end
    launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_7_m2 got=%h exp=fffffffd", res); end
    launch(OP_REM, 32'd7, 32'hFFFF_FFFE);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd1) begin failures++; $display("FAIL rem_7_m2 got=%h exp=1", res); end
    launch(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd14 || lat !== DW + 1) begin failures++; $display("FAIL div_m100_m7 got=%h lat=%0d exp=e lat=%0d", res, lat, DW + 1); end
    launch(OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL rem_m100_m7 got=%h exp=fffffffe", res); end
  endtask

  task automatic test_div_zero();
    logic [DW-1:0] res;
    int lat;
    launch(OP_DIVU, 32'd5, 32'd0);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF || lat !== 1) begin failures++; $display("FAIL divu_by0 got=%h lat=%0d exp=ffffffff lat=1", res, lat); end
    launch(OP_REMU, 32'd5, 32'd0);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd5 || lat !== 1) begin failures++; $display("FAIL remu_by0 got=%h lat=%0d exp=5 lat=1", res, lat); end
    launch(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF || lat !== 1) begin failures++; $display("FAIL div_by0 got=%h lat=%0d exp=ffffffff lat=1", res, lat); end
    launch(OP_REM, 32'hFFFF_FFFB, 32'd0);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFB || lat !== 1) begin failures++; $display("FAIL rem_by0 got=%h lat=%0d exp=fffffffb lat=1", res, lat); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] res;
    int lat;
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'h8000_0000 || lat !== 1) begin failures++; $display("FAIL div_ovf got=%h lat=%0d exp=80000000 lat=1", res, lat); end
    launch(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd0 || lat !== 1) begin failures++; $display("FAIL rem_ovf got=%h lat=%0d exp=0 lat=1", res, lat); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] res;
    int lat;
    int seen;
    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin failures++; $display("FAIL flush_ready ready=%b done=%b exp ready=1 done=0", ready_o, done_o); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_no_done got=%0d pulses exp=0", seen); end
    launch(OP_DIVU, 32'd9, 32'd3);
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd3 || lat !== DW + 1) begin failures++; $display("FAIL after_flush got=%h lat=%0d exp=3 lat=%0d", res, lat, DW + 1); end
  endtask

  task automatic test_busy_start();
    logic [DW-1:0] res;
    int lat;
    launch(OP_DIVU, 32'd100, 32'd7);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start_i     = (k >= 4);
      div_op_i    = OP_REMU;
      operand_a_i = 32'd50;
      operand_b_i = 32'd0;
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    wait_done(100, res, lat);
    checks++;
    if (res !== 32'd14 || lat + 8 !== DW + 1) begin
      failures++; $display("FAIL busy_start_ignored got=%h lat=%0d exp=e lat=%0d", res, lat + 8, DW + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result_o !== 32'd14 || done_o !== 1'b0) begin failures++; $display("FAIL result_hold got=%h done=%b exp=e done=0", result_o, done_o); end
  endtask

  task automatic test_reset_abort();
    int seen;
    launch(OP_DIVU, 32'd77, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    flush_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    start_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || result_o !== '0 || done_o !== 1'b0) begin
      failures++; $display("FAIL reset_abort ready=%b res=%h done=%b exp ready=1 res=0 done=0", ready_o, result_o, done_o);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL reset_abort_no_done got=%0d pulses exp=0", seen); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    start_i     = 1'b0;
    flush_i     = 1'b0;
    div_op_i    = 2'b00;
    operand_a_i = '0;
    operand_b_i = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_busy_start();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
